bubble_position_ctrl: RTL

Frame-synchronous position controller for the ball overlay. Accepts ball-coordinate updates from two requesters (camera tracker and simulation model) through valid/ready ports, selects one source and clamps its coordinates to the visible area. It commits the newest sample to the `bubble_display` `x`/`y` inputs only at the start of vertical blanking, so the ball never tears mid-frame. It also hides the ball when updates stop arriving.

---
 rtl/bubble_position_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bubble_position_ctrl.sv
// Ball position controller: accepts camera/simulation samples, clamps them to the
// visible area, and commits the newest one to the display only at the start of vblank.
module bubble_position_ctrl #(
  parameter int SCREEN_W     = 1024,
  parameter int SCREEN_H     = 768,
  parameter int DIAMETER     = 4,
  parameter int STALE_FRAMES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        use_sim,
  input  logic        cam_valid,
  input  logic [10:0] cam_x,
  input  logic [9:0]  cam_y,
  output logic        cam_ready,
  input  logic        sim_valid,
  input  logic [10:0] sim_x,
  input  logic [9:0]  sim_y,
  output logic        sim_ready,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        bubble_en,
  output logic        stale,
  output logic        frame_tick
);

  localparam int SCW = $clog2(STALE_FRAMES + 1);
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - DIAMETER);
  localparam logic [9:0]  Y_MAX  = 10'(SCREEN_H - DIAMETER);
  localparam logic [10:0] X_RST  = 11'((SCREEN_W - DIAMETER) / 2);
  localparam logic [9:0]  Y_RST  = 10'((SCREEN_H - DIAMETER) / 2);
  localparam logic [SCW-1:0] STALE_MAX = SCW'(STALE_FRAMES);

  typedef enum logic {HIDDEN, SHOWN} state_t;

  state_t         state_q, state_d;
  logic           use_sim_q;
  logic           pend_v_q, pend_v_d;
  logic [10:0]    pend_x_q, pend_x_d;
  logic [9:0]     pend_y_q, pend_y_d;
  logic [10:0]    x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic [SCW-1:0] stale_cnt_q, stale_cnt_d;
  logic           bubble_en_q, bubble_en_d;
  logic           stale_q, stale_d;
  logic           tick_q, tick_d;

  logic           switch_w, take_w, commit_pt_w, commit_w;
  logic [10:0]    in_x, cl_x;
  logic [9:0]     in_y, cl_y;

  // Requesters never stall; ready only drops while reset is held.
  assign cam_ready = ~reset;
  assign sim_ready = ~reset;

  // A select change drops both sources for one cycle; the old selection still
  // applies until the registered copy catches up.
  assign switch_w    = use_sim ^ use_sim_q;
  assign take_w      = ~reset & ~switch_w & (use_sim_q ? sim_valid : cam_valid);
  assign in_x        = use_sim_q ? sim_x : cam_x;
  assign in_y        = use_sim_q ? sim_y : cam_y;
  assign cl_x        = (in_x > X_MAX) ? X_MAX : in_x;
  assign cl_y        = (in_y > Y_MAX) ? Y_MAX : in_y;
  assign commit_pt_w = (hcount == 11'd0) && (vcount == 10'(SCREEN_H));

  always_comb begin
    pend_v_d    = pend_v_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    x_d         = x_q;
    y_d         = y_q;
    stale_cnt_d = stale_cnt_q;
    commit_w    = 1'b0;
    if (commit_pt_w) begin
      pend_v_d = 1'b0;
      if (take_w) begin
        commit_w = 1'b1;
        x_d      = cl_x;
        y_d      = cl_y;
      end else if (pend_v_q && !switch_w) begin
        commit_w = 1'b1;
        x_d      = pend_x_q;
        y_d      = pend_y_q;
      end
      if (commit_w)                      stale_cnt_d = '0;
      else if (stale_cnt_q != STALE_MAX) stale_cnt_d = stale_cnt_q + 1'b1;
    end else if (switch_w) begin
      pend_v_d = 1'b0;
    end else if (take_w) begin
      pend_v_d = 1'b1;
      pend_x_d = cl_x;
      pend_y_d = cl_y;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HIDDEN:  if (commit_w) state_d = SHOWN;
      SHOWN:   if (commit_pt_w && !commit_w && stale_cnt_d == STALE_MAX) state_d = HIDDEN;
      default: state_d = HIDDEN;
    endcase
    bubble_en_d = (state_d == SHOWN);
    stale_d     = (stale_cnt_d == STALE_MAX);
    tick_d      = commit_pt_w;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HIDDEN;
      use_sim_q   <= use_sim;
      pend_v_q    <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      x_q         <= X_RST;
      y_q         <= Y_RST;
      stale_cnt_q <= '0;
      bubble_en_q <= 1'b0;
      stale_q     <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      use_sim_q   <= use_sim;
      pend_v_q    <= pend_v_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      x_q         <= x_d;
      y_q         <= y_d;
      stale_cnt_q <= stale_cnt_d;
      bubble_en_q <= bubble_en_d;
      stale_q     <= stale_d;
      tick_q      <= tick_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign bubble_en  = bubble_en_q;
  assign stale      = stale_q;
  assign frame_tick = tick_q;

endmodule
